// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NREQ producers.
// state  | meaning
// IDLE   | no owner; arbitrate as soon as any requester is valid
// BURST  | grant_id owns the FIFO port until last, BURST_MAX beats or idle timeout
module fifo_wr_arbiter #(
    parameter int WIDTH        = 4,
    parameter int NREQ         = 4,
    parameter int BURST_MAX    = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_w_en,
    output logic [WIDTH-1:0]          fifo_din,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] idle_cnt;

    logic          in_burst;
    logic          g_valid;
    logic          g_last;
    logic          accept;
    logic          idle_tick;
    logic          beat_end;
    logic          timeout_end;
    logic          burst_end;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] arb_ptr;
    logic [NREQ-1:0] arb_valid;
    logic          win_found;
    logic [IW-1:0] win_id;

    assign in_burst    = (state == S_BURST);
    assign busy        = in_burst;
    assign g_valid     = req_valid[grant_id];
    assign g_last      = req_last[grant_id];
    assign accept      = in_burst & g_valid & ~fifo_full;
    assign idle_tick   = in_burst & ~g_valid & ~fifo_full;
    assign beat_end    = accept & (g_last | ((beat_cnt + BW'(1)) == BW'(BURST_MAX)));
    assign timeout_end = idle_tick & (idle_cnt == TW'(IDLE_TIMEOUT - 1));
    assign burst_end   = beat_end | timeout_end;
    assign next_ptr    = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    // At burst end the outgoing owner is masked so it must wait one full pass.
    always_comb begin
        arb_ptr   = rr_ptr;
        arb_valid = req_valid;
        if (in_burst) begin
            arb_ptr             = next_ptr;
            arb_valid[grant_id] = 1'b0;
        end
    end

    always_comb begin
        int s;
        logic [IW-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = int'(arb_ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            idx = IW'(s);
            if (arb_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full) req_ready[grant_id] = 1'b1;
        fifo_w_en = accept;
        fifo_din  = accept ? req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_id <= win_id;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (burst_end) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        if (win_found) grant_id <= win_id;
                        else           state    <= S_IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        idle_cnt <= '0;
                    end else if (idle_tick) begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change just after each falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [3:0]  fifo_din;
    logic [1:0]  grant_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.WIDTH(4), .NREQ(4), .BURST_MAX(4), .IDLE_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_w_en (fifo_w_en),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic setd(input int i, input logic [3:0] v);
        req_data[i*4 +: 4] = v;
    endtask

    task automatic expect_out(input string tag, input logic b, input logic [1:0] g,
                              input logic [3:0] rdy, input logic we, input logic [3:0] d);
        #1;
        check({tag, ".busy"},  32'(busy),      32'(b));
        check({tag, ".grant"}, 32'(grant_id),  32'(g));
        check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".wen"},   32'(fifo_w_en), 32'(we));
        check({tag, ".din"},   32'(fifo_din),  32'(d));
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        #1;
        expect_out("rst", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        check("rst.rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // 1: single requester, 3-beat burst ended by last
        do_reset();
        req_valid = 4'b0001; setd(0, 4'h1);
        expect_out("t1.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        cyc(); expect_out("t1.b1", 1'b1, 2'd0, 4'b0001, 1'b1, 4'h1);
        cyc(); setd(0, 4'h2); expect_out("t1.b2", 1'b1, 2'd0, 4'b0001, 1'b1, 4'h2);
        cyc(); setd(0, 4'h3); req_last = 4'b0001;
        expect_out("t1.b3", 1'b1, 2'd0, 4'b0001, 1'b1, 4'h3);
        cyc(); req_valid = '0; req_last = '0;
        expect_out("t1.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        check("t1.rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // 2: all valid, no last -> 4-beat bursts rotating 0,1,2,3,0 with no bubble
        do_reset();
        req_valid = 4'b1111; req_data = 16'h4321;
        expect_out("t2.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            logic [1:0] g;
            g = 2'((k / 4) % 4);
            cyc();
            expect_out($sformatf("t2.k%0d", k), 1'b1, g, 4'b0001 << g, 1'b1, 4'(g) + 4'h1);
        end

        // 3: requester 1, FIFO full for 5 cycles mid-burst
        do_reset();
        req_valid = 4'b0010; setd(1, 4'h5);
        expect_out("t3.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        cyc(); expect_out("t3.b1", 1'b1, 2'd1, 4'b0010, 1'b1, 4'h5);
        cyc(); setd(1, 4'h6); fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            expect_out($sformatf("t3.full%0d", k), 1'b1, 2'd1, 4'b0000, 1'b0, 4'h0);
        end
        cyc(); fifo_full = 1'b0; expect_out("t3.b2", 1'b1, 2'd1, 4'b0010, 1'b1, 4'h6);
        cyc(); setd(1, 4'h7); expect_out("t3.b3", 1'b1, 2'd1, 4'b0010, 1'b1, 4'h7);
        cyc(); setd(1, 4'h8); req_last = 4'b0010;
        expect_out("t3.b4", 1'b1, 2'd1, 4'b0010, 1'b1, 4'h8);
        cyc(); req_valid = '0; req_last = '0;
        expect_out("t3.idle", 1'b0, 2'd1, 4'b0000, 1'b0, 4'h0);

        // 4: requester 2 goes quiet; released after exactly 8 idle cycles, 3 wins
        req_valid = 4'b0100; setd(2, 4'h9); setd(3, 4'hA);
        expect_out("t4.arb", 1'b0, 2'd1, 4'b0000, 1'b0, 4'h0);
        cyc(); expect_out("t4.b1", 1'b1, 2'd2, 4'b0100, 1'b1, 4'h9);
        cyc(); req_valid = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            expect_out($sformatf("t4.idle%0d", k), 1'b1, 2'd2, 4'b0100, 1'b0, 4'h0);
        end
        cyc(); req_last = 4'b1000;
        expect_out("t4.win3", 1'b1, 2'd3, 4'b1000, 1'b1, 4'hA);
        check("t4.rr_ptr", 32'(dut.rr_ptr), 32'd3);
        cyc(); req_valid = '0; req_last = '0;
        expect_out("t4.idle", 1'b0, 2'd3, 4'b0000, 1'b0, 4'h0);

        // 5: reset asserted on beat 2 of a burst
        do_reset();
        req_valid = 4'b0001; setd(0, 4'h1);
        cyc(); expect_out("t5.b1", 1'b1, 2'd0, 4'b0001, 1'b1, 4'h1);
        cyc(); setd(0, 4'h2); expect_out("t5.b2", 1'b1, 2'd0, 4'b0001, 1'b1, 4'h2);
        reset = 1'b0;
        expect_out("t5.rst", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        cyc(); req_valid = '0; reset = 1'b1;
        cyc(); expect_out("t5.rel", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        check("t5.rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // 6: rr_ptr=1 with requesters 0 and 3 valid -> 3 first, then wrap to 0
        req_valid = 4'b0001; req_last = 4'b0001; setd(0, 4'hC); setd(3, 4'hD);
        cyc(); expect_out("t6.pre", 1'b1, 2'd0, 4'b0001, 1'b1, 4'hC);
        cyc(); req_valid = 4'b1001; req_last = 4'b0000;
        expect_out("t6.arb", 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0);
        check("t6.rr_ptr", 32'(dut.rr_ptr), 32'd1);
        cyc(); req_last = 4'b1000;
        expect_out("t6.win3", 1'b1, 2'd3, 4'b1000, 1'b1, 4'hD);
        cyc(); req_last = 4'b0000;
        expect_out("t6.wrap0", 1'b1, 2'd0, 4'b0001, 1'b1, 4'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
